// File: rtl/adc_serial_reader.sv
// adc_serial_reader: controls an 18-bit simultaneous-sampling ADC and turns its
// two serial outputs into parallel per-channel words.
// Each frame runs CONVST pulse -> wait for BUSY high then low -> CS low and
// clock out N_ADC/2 words on each of DOUTA/DOUTB -> quiet gap -> next frame.
// Channel k of DOUTA is strobed on data_valid_out[k]; the matching DOUTB word
// is strobed one cycle later on data_valid_out[k+N_ADC/2].
// Optional macro ADC_BUSY_TIMEOUT_EN: abandons a frame when a BUSY edge does
// not arrive within BUSY_TIMEOUT cycles, pulsing timeout_out.
module adc_serial_reader #(
    parameter int N_ADC        = 6,
    parameter int W_ADC        = 18,
    parameter int T_CONVST     = 2,
    parameter int T_QUIET      = 4,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic               clk17_in,
    input  logic               reset_in,
    input  logic [2:0]         os_in,
    input  logic               cstart_in,
    input  logic               busy_in,
    input  logic               douta_in,
    input  logic               doutb_in,
    output logic [2:0]         os_out,
    output logic               convst_out,
    output logic               cs_out,
    output logic               sclk_out,
    output logic [N_ADC-1:0]   data_valid_out,
    output logic [W_ADC-1:0]   data_a_out,
    output logic [W_ADC-1:0]   data_b_out,
    output logic               timeout_out
);

    localparam int HALF = N_ADC / 2;
    localparam int BW   = (W_ADC > 1) ? $clog2(W_ADC) : 1;
    localparam int CHW  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CMAX = (T_CONVST > T_QUIET) ? T_CONVST : T_QUIET;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0]  CNV_LAST = CW'(T_CONVST - 1);
    localparam logic [CW-1:0]  Q_LAST   = CW'(T_QUIET - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(W_ADC - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONVST, S_WAIT_HI, S_WAIT_LO, S_READ, S_QUIET
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         os_q, os_d;
    logic               convst_q, convst_d;
    logic               cs_q, cs_d;
    logic               sclk_q, sclk_d;
    logic [N_ADC-1:0]   valid_q, valid_d;
    logic [W_ADC-1:0]   da_q, da_d, db_q, db_d;
    logic [W_ADC-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic               phase_q, phase_d;   // 0: next edge lowers SCLK, 1: next edge raises + samples
    logic [BW-1:0]      bit_q, bit_d;
    logic [CHW-1:0]     ch_q, ch_d;         // channel being shifted
    logic [CHW-1:0]     ld_ch_q, ld_ch_d;   // channel whose word is being published
    logic               load_q, load_d;     // publish A word on the next edge
    logic               strb_q, strb_d;     // publish B strobe on the next edge
    logic               done_q, done_d;     // last bit of last channel is in

`ifdef ADC_BUSY_TIMEOUT_EN
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               timeout_q, timeout_d;
    assign timeout_out = timeout_q;
`else
    localparam int unused_busy_timeout = BUSY_TIMEOUT;
    assign timeout_out = 1'b0;
`endif

    assign os_out         = os_q;
    assign convst_out     = convst_q;
    assign cs_out         = cs_q;
    assign sclk_out       = sclk_q;
    assign data_valid_out = valid_q;
    assign data_a_out     = da_q;
    assign data_b_out     = db_q;

    // Next-state and registered-output logic for the whole frame sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        os_d     = os_q;
        convst_d = convst_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        valid_d  = '0;
        da_d     = da_q;
        db_d     = db_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        ch_d     = ch_q;
        ld_ch_d  = ld_ch_q;
        load_d   = load_q;
        strb_d   = strb_q;
        done_d   = done_q;
`ifdef ADC_BUSY_TIMEOUT_EN
        tmo_d     = '0;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cstart_in) begin
                    state_d  = S_CONVST;
                    os_d     = os_in;
                    convst_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            S_CONVST: begin
                if (cnt_q == CNV_LAST) begin
                    convst_d = 1'b1;
                    state_d  = S_WAIT_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (busy_in) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!busy_in) begin
                    state_d = S_READ;
                    cs_d    = 1'b0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    ch_d    = '0;
                    load_d  = 1'b0;
                    strb_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end
            S_READ: begin
                if (!phase_q) begin
                    if (!done_q) begin
                        sclk_d  = 1'b0;
                        phase_d = 1'b1;
                    end
                end else begin
                    sclk_d  = 1'b1;
                    phase_d = 1'b0;
                    sh_a_d  = {sh_a_q[W_ADC-2:0], douta_in};
                    sh_b_d  = {sh_b_q[W_ADC-2:0], doutb_in};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        load_d  = 1'b1;
                        ld_ch_d = ch_q;
                        if (ch_q == CH_LAST) done_d = 1'b1;
                        else                 ch_d   = ch_q + 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                // A word goes out first; B strobe follows so the two never collide
                if (load_q) begin
                    da_d   = sh_a_q;
                    db_d   = sh_b_q;
                    load_d = 1'b0;
                    strb_d = 1'b1;
                    for (int k = 0; k < HALF; k++)
                        if (ld_ch_q == CHW'(k)) valid_d[k] = 1'b1;
                end
                if (strb_q) begin
                    strb_d = 1'b0;
                    for (int k = 0; k < HALF; k++)
                        if (ld_ch_q == CHW'(k)) valid_d[k+HALF] = 1'b1;
                    if (done_q) begin
                        cs_d    = 1'b1;
                        state_d = S_QUIET;
                        cnt_d   = '0;
                    end
                end
            end
            S_QUIET: begin
                if (cnt_q == Q_LAST) begin
                    state_d  = S_CONVST;
                    os_d     = os_in;
                    convst_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef ADC_BUSY_TIMEOUT_EN
        // Count while the awaited BUSY edge is missing; abandon the frame at the limit
        if ((state_q == S_WAIT_HI && !busy_in) || (state_q == S_WAIT_LO && busy_in)) begin
            if (tmo_q == TMO_LAST) begin
                timeout_d = 1'b1;
                cs_d      = 1'b1;
                state_d   = S_QUIET;
                cnt_d     = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk17_in) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            os_q     <= '0;
            convst_q <= 1'b1;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            valid_q  <= '0;
            da_q     <= '0;
            db_q     <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            phase_q  <= 1'b0;
            bit_q    <= '0;
            ch_q     <= '0;
            ld_ch_q  <= '0;
            load_q   <= 1'b0;
            strb_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ADC_BUSY_TIMEOUT_EN
            tmo_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            os_q     <= os_d;
            convst_q <= convst_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            valid_q  <= valid_d;
            da_q     <= da_d;
            db_q     <= db_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            ch_q     <= ch_d;
            ld_ch_q  <= ld_ch_d;
            load_q   <= load_d;
            strb_q   <= strb_d;
            done_q   <= done_d;
`ifdef ADC_BUSY_TIMEOUT_EN
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader with a behavioural ADC (BUSY + serial data).
module tb_adc_serial_reader;

    localparam int N = 6;
    localparam int W = 18;

    logic           clk = 1'b0;
    logic           reset_in = 1'b1;
    logic [2:0]     os_in = 3'd0;
    logic           cstart_in = 1'b0;
    logic           busy_in = 1'b0;
    logic           douta_in = 1'b0;
    logic           doutb_in = 1'b0;
    logic [2:0]     os_out;
    logic           convst_out, cs_out, sclk_out, timeout_out;
    logic [N-1:0]   data_valid_out;
    logic [W-1:0]   data_a_out, data_b_out;

    int checks = 0;
    int errs   = 0;

    logic [W-1:0]   wa[3];
    logic [W-1:0]   wb[3];
    bit             busy_en = 1'b1;

    always #5 clk = ~clk;

    adc_serial_reader dut (
        .clk17_in(clk), .reset_in(reset_in), .os_in(os_in), .cstart_in(cstart_in),
        .busy_in(busy_in), .douta_in(douta_in), .doutb_in(doutb_in),
        .os_out(os_out), .convst_out(convst_out), .cs_out(cs_out), .sclk_out(sclk_out),
        .data_valid_out(data_valid_out), .data_a_out(data_a_out), .data_b_out(data_b_out),
        .timeout_out(timeout_out)
    );

    // ADC model: BUSY pulse after each CONVST rise, data bits advance after each SCLK rise
    int       bcnt = 0;
    int       nrise = 0;
    logic     cv_prev = 1'b1;
    logic     sk_prev = 1'b1;
    always @(negedge clk) begin
        int ci, bi;
        logic [W-1:0] ta, tb;
        if (!busy_en) begin
            busy_in = 1'b0;
            bcnt    = 0;
        end else begin
            if (convst_out === 1'b1 && cv_prev === 1'b0) bcnt = 1;
            else if (bcnt != 0) bcnt++;
            busy_in = (bcnt >= 2 && bcnt <= 41);
            if (bcnt > 41) bcnt = 0;
        end
        cv_prev = convst_out;
        if (cs_out !== 1'b0) nrise = 0;
        else if (sclk_out === 1'b1 && sk_prev === 1'b0) nrise++;
        sk_prev = sclk_out;
        ci = nrise / W;
        bi = W - 1 - (nrise % W);
        if (ci < 3) begin
            ta = wa[ci];
            tb = wb[ci];
            douta_in = ta[bi];
            doutb_in = tb[bi];
        end else begin
            douta_in = 1'b0;
            doutb_in = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int vidx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_convst"}, convst_out, 1);
        chk({tag, "_cs"}, cs_out, 1);
        chk({tag, "_sclk"}, sclk_out, 1);
        chk({tag, "_os"}, os_out, 0);
        chk({tag, "_valid"}, data_valid_out, 0);
        chk({tag, "_da"}, data_a_out, 0);
        chk({tag, "_db"}, data_b_out, 0);
        chk({tag, "_tmo"}, timeout_out, 0);
    endtask

    // One full frame: latency, strobe order/data, os hold, quiet gap to next CONVST.
    // Also pulses cstart_in during the BUSY wait and during READ, and changes os_in mid-READ.
    task automatic do_frame(input logic [W-1:0] a0, a1, a2, b0, b1, b2, input logic [2:0] os_mid);
        int   exp_ord[6] = '{0, 3, 1, 4, 2, 5};
        logic [W-1:0] ea[3];
        logic [W-1:0] eb[3];
        bit   seen, pulsed;
        int   n, gap;
        logic [2:0] os_rd;
        wa[0] = a0; wa[1] = a1; wa[2] = a2;
        wb[0] = b0; wb[1] = b1; wb[2] = b2;
        ea = wa; eb = wb;
        seen = 0; pulsed = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (busy_in && !pulsed) begin cstart_in = 1'b1; pulsed = 1; end
            else cstart_in = 1'b0;
            step();
            if (cs_out == 1'b0) seen = 1;
        end
        cstart_in = 1'b0;
        chk("cs_fall", seen, 1);
        os_rd = os_out;
        n = 0;
        for (int i = 1; i <= 150; i++) begin
            if (i == 20) begin os_in = os_mid; cstart_in = 1'b1; end
            else cstart_in = 1'b0;
            step();
            if (data_valid_out != '0) begin
                if (n == 0) chk("lat_v0", i, 37);
                chk("onehot", $onehot(data_valid_out), 1);
                chk("order", vidx(data_valid_out), exp_ord[n]);
                if (exp_ord[n] < 3) chk("data_a", data_a_out, ea[exp_ord[n]]);
                else                chk("data_b", data_b_out, eb[exp_ord[n]-3]);
                n++;
                if (n == 6) break;
            end
        end
        cstart_in = 1'b0;
        chk("nvalid", n, 6);
        chk("os_hold", os_out, os_rd);
        step();
        chk("cs_hi", cs_out, 1);
        gap = 1;
        while (convst_out !== 1'b0 && gap < 20) begin
            step();
            gap++;
        end
        chk("quiet_gap", gap, 4);
        chk("os_new", os_out, os_mid);
    endtask

    initial begin
        bit seen, any_v, any_cs, any_cv, any_t;
        int gap, lat;
        wa = '{18'h0, 18'h0, 18'h0};
        wb = '{18'h0, 18'h0, 18'h0};

        // Reset state
        reset_in = 1'b1;
        repeat (3) step();
        chk_reset_vals("rst");
        reset_in = 1'b0;
        os_in = 3'b101;
        step();
        cstart_in = 1'b1;
        step();
        cstart_in = 1'b0;
        chk("os_latch", os_out, 5);
        chk("convst_low", convst_out, 0);

        // Frame with alternating patterns, then boundary words; os change mid-READ
        do_frame(18'h2AAAA, 18'h3FFFF, 18'h20000, 18'h15555, 18'h00001, 18'h3FFFF, 3'd5);
        do_frame(18'h00001, 18'h3FFFF, 18'h20000, 18'h3FFFF, 18'h20000, 18'h00001, 3'd1);
        do_frame(18'h20000, 18'h00001, 18'h3FFFF, 18'h00001, 18'h3FFFF, 18'h20000, 3'd6);

        // Reset mid bit 9 of channel 1
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            if (cs_out == 1'b0) seen = 1;
        end
        chk("rst_cs_fall", seen, 1);
        repeat (55) step();
        chk("pre_rst_sclk", sclk_out, 0);
        chk("pre_rst_da", data_a_out, wa[0]);
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        chk_reset_vals("midrst");
        any_v = 0; any_cs = 0; any_cv = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (data_valid_out != '0) any_v = 1;
            if (cs_out !== 1'b1) any_cs = 1;
            if (convst_out !== 1'b1) any_cv = 1;
        end
        chk("postrst_novalid", any_v, 0);
        chk("postrst_cs_idle", any_cs, 0);
        chk("postrst_convst_idle", any_cv, 0);

        // Clean restart
        os_in = 3'd2;
        cstart_in = 1'b1;
        step();
        cstart_in = 1'b0;
        chk("restart_os", os_out, 2);
        do_frame(18'h12345, 18'h0ABCD, 18'h3FFFE, 18'h00000, 18'h2468A, 18'h1F0F0, 3'd2);

        // BUSY never rises
        busy_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (convst_out == 1'b1) seen = 1;
        end
        chk("whi_entry", seen, 1);
`ifdef ADC_BUSY_TIMEOUT_EN
        lat = 0; any_v = 0;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (data_valid_out != '0) any_v = 1;
            if (timeout_out == 1'b1) begin lat = i; break; end
        end
        chk("tmo_lat", lat, 1024);
        chk("tmo_novalid", any_v, 0);
        chk("tmo_cs", cs_out, 1);
        gap = 0;
        while (convst_out !== 1'b0 && gap < 20) begin
            step();
            gap++;
            if (gap == 1) chk("tmo_pulse_len", timeout_out, 0);
        end
        chk("tmo_quiet_gap", gap, 4);
`else
        any_v = 0; any_cs = 0; any_cv = 0; any_t = 0;
        for (int i = 0; i < 1200; i++) begin
            step();
            if (data_valid_out != '0) any_v = 1;
            if (cs_out !== 1'b1) any_cs = 1;
            if (convst_out !== 1'b1) any_cv = 1;
            if (timeout_out !== 1'b0) any_t = 1;
        end
        chk("hang_novalid", any_v, 0);
        chk("hang_cs", any_cs, 0);
        chk("hang_convst", any_cv, 0);
        chk("hang_tmo", any_t, 0);
        gap = 0; lat = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
